byte_unstriping: RTL
====================

// Module: byte_unstriping
// PURPOSE
// Receive-side counterpart of the two-lane byte striper: merges lane_1/lane_0 back into one
// ordered 32-bit word stream. Each lane is sampled once per two-cycle slot (striper lanes hold
// each word for two cycles). Sampled words go into a show-ahead FIFO drained with a valid/ready
// handshake. Sits between the striped link and the downstream consumer; shares clk/reset with the striper.
// PARAMETERS
// DATA_WIDTH  32  width of lane and output words
// FIFO_DEPTH  8   reassembly FIFO entries; power of 2, >= 2
// CNT_WIDTH   16  width of word_count
// PORTS
// clk         in   1                  clock; all logic on posedge
// reset       in   1                  reset, synchronous, active-high
// lane_0      in   DATA_WIDTH         lane 0 word (odd stream slots)
// valid_0     in   1                  lane 0 word valid
// lane_1      in   DATA_WIDTH         lane 1 word (even slots; first word after reset)
// valid_1     in   1                  lane 1 word valid
// out_ready   in   1                  downstream accepts data_out this cycle
// data_out    out  DATA_WIDTH         FIFO head word
// valid_out   out  1                  FIFO non-empty
// fifo_count  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy
// overflow    out  1                  sticky: a valid word was dropped on a full FIFO
// word_count  out  CNT_WIDTH          total words pushed since reset; wraps
// BEHAVIOUR
// - Reset (sync, high): phase=0, FIFO pointers=0, fifo_count=0, valid_out=0, data_out=0,
//   overflow=0, word_count=0. Reset asserted mid-stream discards all FIFO contents; the next
//   cycle behaves as the first cycle after reset. Striper and unstriper must leave reset together.
// - Phase: 1-bit reg, toggles every non-reset cycle; 0 on the first edge after reset.
// - Sampling at each edge: phase=1 -> sample {valid_1,lane_1}; phase=0 -> sample {valid_0,lane_0}.
//   The unselected lane is ignored that cycle.
// - Push: sampled valid=1 -> write sampled word. Sampled valid=0 is a bubble: no push, and
//   order is kept because slots are positional.
// - Pop: valid_out & out_ready at an edge -> advance read pointer. out_ready with FIFO empty: no-op.
// - data_out = mem[rd_ptr] while valid_out=1; holds last value (no X) when empty.
// - Full without pop: the push is dropped, overflow<=1 (sticky until reset), word_count unchanged.
// - Full with simultaneous pop: the push is accepted and fifo_count stays FIFO_DEPTH.
// - Empty with push: the word appears on data_out/valid_out the cycle after the sample edge.
//   Total latency: striper input sample edge -> data_out valid is 2 edges.
// - Push and pop together at 0<count<DEPTH: count unchanged. Pointers wrap modulo FIFO_DEPTH.
// - word_count += 1 on each accepted push; wraps 2^CNT_WIDTH-1 -> 0.
// - Arithmetic: pointers are log2(FIFO_DEPTH) bits plus a wrap bit for the full/empty compare.
// TESTING
// T1 striper fed A,B,C,D contiguous, out_ready=1 -> data_out A,B,C,D in consecutive cycles;
//    A valid 2 edges after striper samples it; word_count=4, overflow=0.
// T2 striper stream A,-,B,-,-,C (bubbles) -> output A,B,C in order, no spurious pushes; word_count=3.
// T3 out_ready=0, 9 contiguous words, DEPTH=8 -> fifo_count=8, overflow=1, word_count=8;
//    then out_ready=1 -> first 8 words out in order, valid_out drops.
// T4 FIFO full, push and out_ready=1 together -> accepted, fifo_count stays 8, overflow stays 0.
// T5 reset for 1 cycle mid-burst after 3 words -> valid_out=0, fifo_count=0, word_count=0;
//    new burst X,Y after joint reset release -> X,Y out in order.
// T6 CNT_WIDTH=4, 17 words with out_ready=1 -> word_count reads 1 after wrap; data unaffected.

Source files
------------

// File: rtl/byte_unstriping.sv
// Two-lane receive-side unstriper: samples lane_1/lane_0 on alternating edges and
// reassembles the word stream in a show-ahead FIFO drained by valid/ready.
module byte_unstriping #(
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 8,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [DATA_WIDTH-1:0]         lane_0,
  input  logic                          valid_0,
  input  logic [DATA_WIDTH-1:0]         lane_1,
  input  logic                          valid_1,
  input  logic                          out_ready,
  output logic [DATA_WIDTH-1:0]         data_out,
  output logic                          valid_out,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overflow,
  output logic [CNT_WIDTH-1:0]          word_count
);

  localparam int AW = $clog2(FIFO_DEPTH);

  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [AW:0]           wr_ptr, rd_ptr, wr_next, rd_next;
  logic                  phase;
  logic                  sample_valid;
  logic [DATA_WIDTH-1:0] sample_data;
  logic                  full, pop, push;
  logic [DATA_WIDTH-1:0] head_next;

  always_comb begin
    sample_valid = phase ? valid_1 : valid_0;
    sample_data  = phase ? lane_1  : lane_0;
    full = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    pop  = valid_out & out_ready;
    // A pop in the same cycle frees the slot, so a full FIFO can still accept.
    push = sample_valid & (~full | pop);
    wr_next = wr_ptr + (AW+1)'(push);
    rd_next = rd_ptr + (AW+1)'(pop);
    // New head is the word being written when it lands in the slot rd_next points at.
    head_next = (push && (rd_next[AW-1:0] == wr_ptr[AW-1:0])) ? sample_data
                                                              : mem[rd_next[AW-1:0]];
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= sample_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      phase      <= 1'b0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      valid_out  <= 1'b0;
      data_out   <= '0;
      overflow   <= 1'b0;
      word_count <= '0;
    end else begin
      phase      <= ~phase;
      wr_ptr     <= wr_next;
      rd_ptr     <= rd_next;
      fifo_count <= wr_next - rd_next;
      valid_out  <= (wr_next != rd_next);
      if (wr_next != rd_next) data_out <= head_next;
      if (sample_valid && !push) overflow <= 1'b1;
      if (push) word_count <= word_count + CNT_WIDTH'(1);
    end
  end

endmodule
